mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares a single memory port between the instruction fetcher and the load/store queue, so the core can sit behind one cache/memory interface. Each side keeps its own held-until-response request interface. A registered FSM grants one requester at a time and latches that requester's command for the whole transaction. It also absorbs fetches that a pipeline flush has made obsolete. The block sits between the core's i_mem/lsq_mem ports and the memory-side port.

## Interface
- width, 32, address/data width
- starve_max, 2, consecutive data grants allowed while a fetch waits
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_read  in  1  fetch read request, held until i_resp
- i_address  in  width  fetch address
- i_flush  in  1  one-cycle pulse; any pending or in-flight fetch is obsolete
- i_resp  out  1  fetch done, one cycle
- i_rdata  out  width  fetch data, valid with i_resp
- d_read  in  1  LSQ read request, held until d_resp
- d_write  in  1  LSQ write request, held until d_resp
- d_byte_enable  in  width/8  LSQ byte enables
- d_address  in  width  LSQ address
- d_wdata  in  width  LSQ write data
- d_resp  out  1  LSQ done, one cycle
- d_rdata  out  width  LSQ read data, valid with d_resp
- mem_read  out  1  memory read, held until mem_resp
- mem_write  out  1  memory write, held until mem_resp
- mem_byte_enable  out  width/8  memory byte enables
- mem_address  out  width  memory address
- mem_wdata  out  width  memory write data
- mem_resp  in  1  memory done, one cycle
- mem_rdata  in  width  memory read data

## Operation
- **States:** IDLE, SERVE_I, SERVE_D, DRAIN_I.
- **IDLE, grant rule:**
  - d_read|d_write is pending and starve_cnt < starve_max: grant D, go to SERVE_D.
  - Otherwise, i_read is pending and i_flush is 0: grant I, go to SERVE_I.
  - Otherwise, if D is pending, grant D.
  - Otherwise, stay in IDLE.
- **Command latch:** on a grant, address, wdata, byte_enable and the read/write type are captured into command registers. mem_* are driven only from these registers. Fetch grants drive byte_enable 4'hF and wdata 0.
- **SERVE_I:**
  - mem_resp with no flush: i_resp=1, i_rdata=mem_rdata, go to IDLE.
  - i_flush without mem_resp: go to DRAIN_I.
  - i_flush in the same cycle as mem_resp: i_resp is suppressed, go to IDLE.
- **DRAIN_I:** mem_read stays high until mem_resp, because an issued access is never cancelled. On mem_resp, i_resp stays 0 and the state returns to IDLE. Further i_flush pulses have no effect.
- **SERVE_D:** on mem_resp, d_resp=1, d_rdata=mem_rdata (don't-care for writes), go to IDLE.
- **starve_cnt** (2 bits, saturating at starve_max):
  - Increments on each D grant made while i_read is high.
  - Clears on any I grant, or whenever i_read is low in IDLE.
- **Illegal input:** d_read and d_write both high. The bench flags it; the RTL treats it as a write.
- **Unchanged inputs:** requester inputs that change mid-transaction do not affect the mem_* outputs.
- **Reset:** state=IDLE, starve_cnt=0, command registers cleared. Reset mid-transaction abandons the transaction; memory must also be reset.

## Timing
- **Reset values:** i_resp, d_resp, mem_read, mem_write = 0; mem_address, mem_wdata, i_rdata, d_rdata = 0; mem_byte_enable = 0.
- **Grant latency:** the request is sampled in IDLE, and mem_read/mem_write rises the following cycle.
- **Response path:** i_resp/d_resp and the rdata outputs are combinational from mem_resp/mem_rdata in the same cycle.
- **Memory-side strobes:** mem_read/mem_write drop in the cycle after mem_resp.
- **Gap between transactions:** the FSM returns to IDLE the cycle after mem_resp. The earliest next mem strobe is 2 cycles after mem_resp, i.e. exactly one idle cycle between back-to-back transactions.
- **Requester side:** a requester may drop its request in the cycle after its resp or issue a new one then. Sampling happens in IDLE, so that sample is always a fresh request.
- **Flush timing:** i_flush is sampled every cycle. i_flush in IDLE together with i_read blocks the I grant that cycle; D may be granted instead.
- **Minimum transaction:** 3 cycles (grant, mem_resp, IDLE) when memory responds in the first strobe cycle.

## Test plan
- Only i_read at 0x60 with mem_resp after 3 strobe cycles. Required: mem_read high for 3 cycles, mem_address=0x60, mem_byte_enable=4'hF, i_resp one cycle with i_rdata=mem_rdata=0x00000013.
- i_read and d_write (addr 0x100, wdata 0xDEADBEEF, be 4'b0011) raised in the same cycle. Required: D granted first with mem_write/mem_wdata/byte_enable matching; I granted next, after one IDLE cycle.
- LSQ issues back-to-back reads while i_read is held, starve_max=2. Required: grant order D, D, I, D, D, I; no fetch waits more than 2 data transactions.
- i_flush pulsed in the second cycle of SERVE_I. Required: mem_read stays high until mem_resp, i_resp never asserts, next fetch at a new address granted afterwards.
- i_flush in the same cycle as mem_resp in SERVE_I. Required: no i_resp, FSM in IDLE next cycle. Also: i_flush with i_read in IDLE and no D pending. Required: no grant that cycle.
- rst asserted during SERVE_D. Required: all outputs 0 the next cycle, state IDLE, starve_cnt=0, stale mem_resp after reset ignored.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch and the LSQ.
// The granted command is latched for the whole transaction; flushed fetches are drained silently.
module mem_port_arbiter #(
   parameter int width      = 32,
   parameter int starve_max = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_read,
   input  logic [width-1:0]   i_address,
   input  logic               i_flush,
   output logic               i_resp,
   output logic [width-1:0]   i_rdata,
   input  logic               d_read,
   input  logic               d_write,
   input  logic [width/8-1:0] d_byte_enable,
   input  logic [width-1:0]   d_address,
   input  logic [width-1:0]   d_wdata,
   output logic               d_resp,
   output logic [width-1:0]   d_rdata,
   output logic               mem_read,
   output logic               mem_write,
   output logic [width/8-1:0] mem_byte_enable,
   output logic [width-1:0]   mem_address,
   output logic [width-1:0]   mem_wdata,
   input  logic               mem_resp,
   input  logic [width-1:0]   mem_rdata
);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DRAIN_I} state_t;

   localparam logic [1:0] STARVE_LIM = 2'(starve_max);

   state_t     state;
   logic [1:0] starve_cnt;
   logic       d_pend;
   logic       grant_d;
   logic       grant_i;

   assign d_pend = d_read | d_write;

   // D wins until it has starved a waiting fetch starve_max times; flush blocks an I grant.
   always_comb begin
      grant_d = 1'b0;
      grant_i = 1'b0;
      if (state == IDLE) begin
         if (d_pend && (starve_cnt < STARVE_LIM))
            grant_d = 1'b1;
         else if (i_read && !i_flush)
            grant_i = 1'b1;
         else if (d_pend)
            grant_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         starve_cnt      <= 2'd0;
         mem_read        <= 1'b0;
         mem_write       <= 1'b0;
         mem_byte_enable <= '0;
         mem_address     <= '0;
         mem_wdata       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_d) begin
                  state           <= SERVE_D;
                  mem_read        <= d_read & ~d_write;
                  mem_write       <= d_write;
                  mem_byte_enable <= d_byte_enable;
                  mem_address     <= d_address;
                  mem_wdata       <= d_wdata;
                  if (!i_read)
                     starve_cnt <= 2'd0;
                  else if (starve_cnt < STARVE_LIM)
                     starve_cnt <= starve_cnt + 2'd1;
               end else if (grant_i) begin
                  state           <= SERVE_I;
                  mem_read        <= 1'b1;
                  mem_write       <= 1'b0;
                  mem_byte_enable <= '1;
                  mem_address     <= i_address;
                  mem_wdata       <= '0;
                  starve_cnt      <= 2'd0;
               end else if (!i_read) begin
                  starve_cnt <= 2'd0;
               end
            end
            SERVE_I: begin
               if (mem_resp) begin
                  state     <= IDLE;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
               end else if (i_flush) begin
                  state <= DRAIN_I;
               end
            end
            // An issued access is never cancelled; wait for memory before going idle.
            SERVE_D, DRAIN_I: begin
               if (mem_resp) begin
                  state     <= IDLE;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign i_resp  = (state == SERVE_I) && mem_resp && !i_flush;
   assign i_rdata = i_resp ? mem_rdata : '0;
   assign d_resp  = (state == SERVE_D) && mem_resp;
   assign d_rdata = d_resp ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter: stimulus queues expected grants/responses,
// a negedge monitor pops and compares them as the DUT presents strobes and resp pulses.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_read, i_flush, i_resp;
   logic [31:0] i_address, i_rdata;
   logic        d_read, d_write, d_resp;
   logic [3:0]  d_byte_enable;
   logic [31:0] d_address, d_wdata, d_rdata;
   logic        mem_read, mem_write, mem_resp;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_address, mem_wdata, mem_rdata;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } gnt_t;

   typedef struct {
      logic        care;
      logic [31:0] data;
   } dexp_t;

   gnt_t        exp_g[$];
   logic [31:0] exp_i[$];
   dexp_t       exp_d[$];

   int n_cmp = 0;
   int n_bad = 0;

   mem_port_arbiter #(.width(32), .starve_max(2)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address), .i_flush(i_flush),
      .i_resp(i_resp), .i_rdata(i_rdata),
      .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
      .d_address(d_address), .d_wdata(d_wdata),
      .d_resp(d_resp), .d_rdata(d_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
      .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_resp(mem_resp), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // kind: 0 = no response expected, 1 = fetch resp, 2 = LSQ read resp, 3 = LSQ write resp
   task automatic mem_txn(input int lat, input logic [31:0] data, input int kind);
      int n;
      n = 0;
      while (!(mem_read || mem_write) && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) begin
         n_cmp++;
         n_bad++;
         $display("FAIL strobe_timeout: got no strobe, expected one within 20 cycles");
         return;
      end
      repeat (lat - 1) tick();
      mem_resp  = 1'b1;
      mem_rdata = data;
      case (kind)
         1: exp_i.push_back(data);
         2: exp_d.push_back('{1'b1, data});
         3: exp_d.push_back('{1'b0, data});
         default: ;
      endcase
      tick();
      mem_resp  = 1'b0;
      mem_rdata = '0;
   endtask

   // Monitor: compares every new strobe and every resp pulse against the queues
   initial begin
      logic  strobe_q;
      gnt_t  g;
      dexp_t de;
      logic [31:0] ie;
      strobe_q = 1'b0;
      forever begin
         @(negedge clk);
         if (d_read && d_write)
            $display("note: d_read and d_write both high (illegal); write grant expected");
         if ((mem_read || mem_write) && !strobe_q) begin
            if (exp_g.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_grant: got strobe at addr %0h, expected none", mem_address);
            end else begin
               g = exp_g.pop_front();
               check("grant_type", {mem_write, mem_read}, {g.wr, ~g.wr});
               check("grant_addr", mem_address, g.addr);
               check("grant_wdata", mem_wdata, g.wdata);
               check("grant_be", mem_byte_enable, g.be);
            end
         end
         strobe_q = mem_read || mem_write;
         check("strobes_exclusive", mem_read & mem_write, 0);
         if (i_resp) begin
            if (exp_i.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_i_resp: got i_resp data %0h, expected none", i_rdata);
            end else begin
               ie = exp_i.pop_front();
               check("i_rdata", i_rdata, ie);
            end
         end
         if (d_resp) begin
            if (exp_d.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_d_resp: got d_resp data %0h, expected none", d_rdata);
            end else begin
               de = exp_d.pop_front();
               if (de.care) check("d_rdata", d_rdata, de.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      i_read = 0; i_address = 0; i_flush = 0;
      d_read = 0; d_write = 0; d_byte_enable = 0; d_address = 0; d_wdata = 0;
      mem_resp = 0; mem_rdata = 0;
      tick(); tick();
      check("rst_strobes", {mem_read, mem_write, i_resp, d_resp}, 0);
      check("rst_addr", mem_address, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_be", mem_byte_enable, 0);
      check("rst_rdata", {i_rdata, d_rdata}, 0);
      rst = 1'b0;
      tick();

      // single fetch, memory answers in third strobe cycle
      i_read = 1; i_address = 32'h60;
      exp_g.push_back('{1'b0, 32'h60, 32'h0, 4'hF});
      tick(); check("t1_grant_latency", mem_read, 1);
      tick(); check("t1_hold2", mem_read, 1);
      tick(); check("t1_hold3", mem_read, 1);
      mem_resp = 1; mem_rdata = 32'h13;
      exp_i.push_back(32'h13);
      tick();
      mem_resp = 0; mem_rdata = 0; i_read = 0;
      check("t1_strobe_drop", mem_read, 0);
      tick();

      // simultaneous fetch and write: D first, I after one idle cycle
      i_read = 1; i_address = 32'h84;
      d_write = 1; d_address = 32'h100; d_wdata = 32'hDEADBEEF; d_byte_enable = 4'b0011;
      exp_g.push_back('{1'b1, 32'h100, 32'hDEADBEEF, 4'b0011});
      exp_g.push_back('{1'b0, 32'h84, 32'h0, 4'hF});
      mem_txn(1, 32'h0, 3);
      d_write = 0;
      check("t2_idle_gap", mem_read | mem_write, 0);
      tick(); check("t2_i_grant", mem_read, 1);
      mem_txn(1, 32'h84840000, 1);
      i_read = 0;
      tick();

      // starvation bound: D, D, I, D, D, I
      i_read = 1; i_address = 32'h40;
      d_read = 1; d_address = 32'h300; d_wdata = 0; d_byte_enable = 4'hF;
      exp_g.push_back('{1'b0, 32'h300, 32'h0, 4'hF});
      exp_g.push_back('{1'b0, 32'h304, 32'h0, 4'hF});
      exp_g.push_back('{1'b0, 32'h40, 32'h0, 4'hF});
      exp_g.push_back('{1'b0, 32'h308, 32'h0, 4'hF});
      exp_g.push_back('{1'b0, 32'h30C, 32'h0, 4'hF});
      exp_g.push_back('{1'b0, 32'h44, 32'h0, 4'hF});
      mem_txn(1, 32'h1000, 2); d_address = 32'h304;
      mem_txn(1, 32'h1004, 2); d_address = 32'h308;
      mem_txn(1, 32'h2040, 1); i_address = 32'h44;
      mem_txn(1, 32'h1008, 2); d_address = 32'h30C;
      mem_txn(1, 32'h100C, 2); d_read = 0;
      mem_txn(1, 32'h2044, 1); i_read = 0;
      tick();

      // flush in second SERVE_I cycle: drained, no i_resp, then refetch
      i_read = 1; i_address = 32'h80;
      exp_g.push_back('{1'b0, 32'h80, 32'h0, 4'hF});
      tick(); tick();
      i_flush = 1;
      tick(); i_flush = 0; i_address = 32'hA0;
      check("t4_drain_hold1", mem_read, 1);
      tick(); i_flush = 1;
      check("t4_drain_hold2", mem_read, 1);
      tick(); i_flush = 0;
      mem_resp = 1; mem_rdata = 32'hBAD;
      check("t4_no_i_resp", i_resp, 0);
      tick(); mem_resp = 0; mem_rdata = 0;
      check("t4_drain_drop", mem_read, 0);
      exp_g.push_back('{1'b0, 32'hA0, 32'h0, 4'hF});
      mem_txn(2, 32'hA0A0, 1);
      i_read = 0;
      tick();

      // flush coinciding with mem_resp: no resp, IDLE next cycle
      i_read = 1; i_address = 32'hC0;
      exp_g.push_back('{1'b0, 32'hC0, 32'h0, 4'hF});
      tick();
      mem_resp = 1; mem_rdata = 32'h55; i_flush = 1;
      check("t5_flush_resp_suppressed", i_resp, 0);
      tick();
      mem_resp = 0; mem_rdata = 0; i_flush = 0; i_address = 32'hC4;
      check("t5_strobe_drop", mem_read, 0);
      exp_g.push_back('{1'b0, 32'hC4, 32'h0, 4'hF});
      tick(); check("t5_idle_then_grant", mem_read, 1);
      mem_txn(1, 32'hC4C4, 1);
      i_read = 0;
      tick();

      // flush in IDLE with fetch only: no grant that cycle
      i_read = 1; i_address = 32'hE0; i_flush = 1;
      tick(); i_flush = 0;
      check("t5_flush_blocks_grant", mem_read | mem_write, 0);
      exp_g.push_back('{1'b0, 32'hE0, 32'h0, 4'hF});
      tick(); check("t5_grant_after_flush", mem_read, 1);
      mem_txn(1, 32'hE0E0, 1);
      i_read = 0;
      tick();

      // illegal read+write is a write; later input changes do not reach mem_*
      d_read = 1; d_write = 1; d_address = 32'h400; d_wdata = 32'h12345678; d_byte_enable = 4'b1100;
      exp_g.push_back('{1'b1, 32'h400, 32'h12345678, 4'b1100});
      tick(); check("t6_write_wins", {mem_write, mem_read}, 2'b10);
      d_read = 0; d_address = 32'hFFC; d_wdata = 0; d_byte_enable = 4'hF;
      tick();
      check("t6_addr_held", mem_address, 32'h400);
      check("t6_wdata_held", mem_wdata, 32'h12345678);
      check("t6_be_held", mem_byte_enable, 4'b1100);
      mem_txn(1, 32'h0, 3);
      d_write = 0;
      tick();

      // reset in SERVE_D with starve_cnt at limit; counter must restart at 0
      i_read = 1; i_address = 32'h600;
      d_read = 1; d_address = 32'h500; d_wdata = 0; d_byte_enable = 4'hF;
      exp_g.push_back('{1'b0, 32'h500, 32'h0, 4'hF});
      exp_g.push_back('{1'b0, 32'h504, 32'h0, 4'hF});
      exp_g.push_back('{1'b0, 32'h508, 32'h0, 4'hF});
      exp_g.push_back('{1'b0, 32'h600, 32'h0, 4'hF});
      mem_txn(1, 32'h5000, 2); d_address = 32'h504;
      tick(); check("t8_serve_d", mem_read, 1);
      rst = 1;
      tick();
      check("t8_rst_strobes", {mem_read, mem_write, i_resp, d_resp}, 0);
      check("t8_rst_addr", mem_address, 0);
      check("t8_rst_be", mem_byte_enable, 0);
      rst = 0; d_address = 32'h508;
      mem_resp = 1; mem_rdata = 32'h77;
      check("t8_stale_resp_ignored", d_resp, 0);
      tick(); mem_resp = 0; mem_rdata = 0;
      mem_txn(1, 32'h5080, 2); d_read = 0;
      mem_txn(1, 32'h6000, 1); i_read = 0;
      tick(); tick();

      check("grant_queue_drained", exp_g.size(), 0);
      check("i_queue_drained", exp_i.size(), 0);
      check("d_queue_drained", exp_d.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
